// File: rtl/bin_frac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_frac_pkg
// Description : Shared constants and FSM state encoding for the sequential
//               sign-magnitude fractional multiplier and divider.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_frac_pkg;

  // Magnitude bits of a single-width fraction; the sign sits above them.
  localparam int FRAC_W   = 6;
  localparam int SIGN_BIT = FRAC_W;
  // Double-width fraction: sign plus 2*FRAC_W magnitude bits.
  localparam int DBL_W    = 2 * FRAC_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    CALC   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/frac_div_step.sv
`default_nettype none
// ============================================================================
// Module      : frac_div_step
// Description : One restoring-division step: shift the partial remainder left
//               by one dividend bit, trial-subtract the divisor and keep the
//               difference only when it is non-negative.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_div_step
  import bin_frac_pkg::*;
(
  input  logic [FRAC_W-1:0] p_i,
  input  logic              d_msb_i,
  input  logic [FRAC_W-1:0] b_i,
  output logic [FRAC_W-1:0] p_o,
  output logic              q_bit_o
);

  // The shifted value needs one extra bit to hold the carry out of P.
  logic [FRAC_W:0] w_shift;
  logic [FRAC_W:0] w_diff;
  logic            w_unused_diff_msb;

  // Trial subtract and restore; P < B always holds, so the kept value fits.
  always_comb begin
    w_shift           = {p_i, d_msb_i};
    w_diff            = w_shift - {1'b0, b_i};
    q_bit_o           = (w_shift >= {1'b0, b_i});
    p_o               = q_bit_o ? w_diff[FRAC_W-1:0] : w_shift[FRAC_W-1:0];
    w_unused_diff_msb = w_diff[FRAC_W];
  end

endmodule
`default_nettype wire

// File: rtl/bin_frac_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : bin_frac_seq_div
// Description : Sequential restoring divider for sign-magnitude fractions.
//               13-bit dividend / 7-bit divisor -> 7-bit quotient and
//               remainder, one quotient bit per clock, start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_frac_seq_div
  import bin_frac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DBL_W-1:0] a,
  input  logic [FRAC_W:0]  b,
  output logic [FRAC_W:0]  quotient,
  output logic [FRAC_W:0]  remainder,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int              CNT_W       = $clog2(FRAC_W);
  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(FRAC_W - 1);

  state_e              state_q, state_d;
  logic                w_accept;
  logic [DBL_W-2:0]    a_q;
  logic [FRAC_W-1:0]   b_q;
  logic                sq_q, sr_q;
  logic [FRAC_W-1:0]   p_q;
  logic [FRAC_W-1:0]   d_q;
  logic [FRAC_W-2:0]   q_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FRAC_W-1:0]   w_a_hi;
  logic [FRAC_W-1:0]   w_p_next;
  logic                w_q_bit;
  logic [FRAC_W-1:0]   w_q_final;

  assign w_a_hi    = a_q[DBL_W-2:FRAC_W];
  assign w_q_final = {q_q, w_q_bit};

  frac_div_step u_step (
    .p_i     (p_q),
    .d_msb_i (d_q[FRAC_W-1]),
    .b_i     (b_q),
    .p_o     (w_p_next),
    .q_bit_o (w_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; a start in FINISH chains the next divide
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if ((b_q == '0) || (w_a_hi >= b_q)) begin
          state_d = FINISH;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == c_last_step) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          state_d  = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      p_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        a_q         <= a[DBL_W-2:0];
        b_q         <= b[FRAC_W-1:0];
        sq_q        <= a[DBL_W-1] ^ b[SIGN_BIT];
        sr_q        <= a[DBL_W-1];
        overflow    <= 1'b0;
        div_by_zero <= 1'b0;
      end
      case (state_q)
        CHECK: begin
          if (b_q == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
          end else if (w_a_hi >= b_q) begin
            overflow    <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
          end else begin
            p_q   <= w_a_hi;
            d_q   <= a_q[FRAC_W-1:0];
            q_q   <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          p_q   <= w_p_next;
          d_q   <= {d_q[FRAC_W-2:0], 1'b0};
          q_q   <= {q_q[FRAC_W-3:0], w_q_bit};
          cnt_q <= cnt_q + 1'b1;
          // Signs are dropped on zero magnitudes so -0 never appears.
          if (cnt_q == c_last_step) begin
            quotient  <= {sq_q & (w_q_final != '0), w_q_final};
            remainder <= {sr_q & (w_p_next != '0), w_p_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bin_frac_seq_div.md
Name: bin_frac_seq_div

Overview:
Sequential restoring divider for sign-magnitude binary fractions; the inverse operation of the team's sequential fractional multiplier.
- Takes a 13-bit double-width fraction, in the same format as the multiplier's product, and a 7-bit divisor fraction.
- Returns a 7-bit quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the lab ALU datapath and uses the same start/done handshake.

Parameters:
FRAC_W, 6, magnitude bits of a single-width fraction. Sign is the MSB; the dividend carries 2*FRAC_W magnitude bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; sampled only when busy=0.
a  input  2*FRAC_W+1 (13)  dividend: a[12] sign, a[11:0] magnitude, weight 2^-12.
b  input  FRAC_W+1 (7)  divisor: b[6] sign, b[5:0] magnitude, weight 2^-6.
quotient  output  FRAC_W+1 (7)  q[6] sign, q[5:0] magnitude, weight 2^-6.
remainder  output  FRAC_W+1 (7)  r[6] sign, r[5:0] magnitude, weight 2^-12.
done  output  1  one-cycle pulse when results are valid.
busy  output  1  high while a division is in progress.
overflow  output  1  |a| >= |b|; valid with done.
div_by_zero  output  1  b magnitude is zero; valid with done.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE. quotient, remainder, done, busy, overflow and div_by_zero are all 0. Reset overrides everything, including mid-division; the aborted result is discarded.
- Magnitude rule: A = a[11:0] and B = b[5:0].
  - Q = floor(A/B) and R = A - Q*B.
  - Legal only if B != 0 and A[11:6] < B, which guarantees Q < 64.
- State IDLE:
  - busy=0.
  - On start: latch A and B, latch sq = a[12]^b[6] and sr = a[12], clear the error flags, go to CHECK, busy=1.
- State CHECK (1 cycle):
  - If B==0: div_by_zero=1, go to FINISH.
  - Else if A[11:6] >= B: overflow=1, go to FINISH.
  - Otherwise: partial remainder P = A[11:6] (7-bit to hold the shift carry), dividend shift register D = A[5:0], counter = 0, go to CALC.
- State CALC (exactly FRAC_W = 6 cycles). Each cycle:
  - T = {P[5:0], D[5]} - {0,B}.
  - If T is non-negative: P = T and shift 1 into Q. Otherwise P = {P[5:0], D[5]} and shift 0 into Q.
  - D shifts left; counter increments.
  - After the 6th step go to FINISH.
- State FINISH (1 cycle):
  - done=1, busy=0.
  - Normal case: quotient = {sq & (Q!=0), Q}, remainder = {sr & (R!=0), R}. Negative zero is never produced.
  - Error case: quotient=0, remainder=0, with overflow or div_by_zero held at 1.
  - Next state is IDLE. A start in this cycle is accepted, which allows back-to-back operation.
- Latency, counted from the start-sample edge:
  - Legal operand: done is high in the 8th cycle (1 CHECK + 6 CALC + FINISH).
  - Error: done is high in the 2nd cycle.
- Output holding: quotient, remainder and the error flags hold their values until the next FINISH or reset. done is a single-cycle pulse.
- start while busy=1 is ignored; a and b may change freely after the sample edge.
- Round-trip property: when no error occurs, quotient*b + remainder == a in magnitude.

Decomposition:
- Shared package bin_frac_pkg: FRAC_W, the state enum {IDLE, CHECK, CALC, FINISH}, and the SIGN_BIT and DBL_W (= 2*FRAC_W+1) constants. The multiplier uses the same package.
- One natural sub-module, frac_div_step: combinational shift/trial-subtract/restore cell (inputs P, D msb, B; outputs new P and q bit). It is instantiated once and reused each CALC cycle.

Test Plan:
- Round-trip with the multiplier: a=13'b0_000000001000, b=7'b0_000010 -> quotient=7'b0000100, remainder=0, done pulse 8 cycles after start, overflow=0.
- Fraction result: a=13'b0_000010000000 (1/32), b=7'b0_000100 (1/16) -> quotient=7'b0100000 (0.5), remainder=0.
- Signs and remainder: a=13'b1_000000001011, b=7'b0_000010 -> quotient=7'b1000101, remainder=7'b1000001. Also a=13'b1_000000000000, b=7'b0_000101 -> quotient=7'b0000000 (sign cleared).
- Errors:
  - b=7'b1000000 -> div_by_zero=1, done 2 cycles after start, quotient=0.
  - a=13'b0_000011000000, b=7'b0_000011 -> overflow=1, remainder=0.
- Handshake:
  - Start pulsed again 3 cycles into CALC -> ignored; the first result is unaffected.
  - Start in the FINISH cycle -> the second division completes 8 cycles later.
- Reset: rst asserted in the 4th CALC cycle -> next cycle all outputs are 0 and state is IDLE; a new start completes normally.
